alu_op_driver: RTL
==================

// Module: alu_op_driver
// PURPOSE
//  Sequential initiator that drives the combinational ALU: accepts one command (A, B, OpCode) on a
//  valid/ready port, registers and holds it on the ALU inputs, waits SETTLE_CYC cycles, then samples
//  Result/Z_flag/C_flag/C_out and returns them on a valid/ready response port.
//  Sits between a control/sequencer block and the ALU; the ALU is instantiated by the parent.
// PARAMETERS
//  N          8  operand/result width; must match the ALU's n
//  SETTLE_CYC 1  clock edges between driving ALU inputs and sampling outputs; legal range 1..15
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  cmd_valid   in   1  command present
//  cmd_ready   out  1  driver can accept a command
//  cmd_a       in   N  operand A
//  cmd_b       in   N  operand B
//  cmd_op      in   3  ALU OpCode
//  alu_a       out  N  to ALU A (registered)
//  alu_b       out  N  to ALU B (registered)
//  alu_opcode  out  3  to ALU OpCode (registered)
//  alu_result  in   N  from ALU Result
//  alu_z       in   1  from ALU Z_flag
//  alu_c       in   1  from ALU C_flag
//  alu_cout    in   1  from ALU C_out
//  rsp_valid   out  1  response present
//  rsp_ready   in   1  consumer takes the response
//  rsp_result  out  N  captured Result
//  rsp_flags   out  3  captured {C_out, C_flag, Z_flag}
//  rsp_op      out  3  echo of the OpCode that produced this response
// BEHAVIOUR
//  Reset (rst_n=0): state IDLE; cmd_ready=0; rsp_valid=0; alu_a, alu_b, alu_opcode, rsp_result,
//   rsp_flags and rsp_op all 0. cmd_ready rises on the first clk edge after reset release.
//  FSM IDLE -> SETTLE -> RESP -> IDLE:
//   IDLE:   cmd_ready=1. On cmd_valid&&cmd_ready: load alu_a/alu_b/alu_opcode from cmd_*,
//           set cnt=SETTLE_CYC-1, go to SETTLE, drop cmd_ready.
//   SETTLE: if cnt==0, capture alu_result/flags and alu_opcode into the rsp_* registers, assert
//           rsp_valid, go to RESP. Otherwise decrement cnt.
//   RESP:   hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: clear rsp_valid,
//           go to IDLE. cmd_ready rises on the next edge.
//  Latency: with accept at edge t, rsp_valid is high from edge t+SETTLE_CYC.
//   Minimum issue interval is SETTLE_CYC+2 cycles.
//  alu_* hold the last command until the next accept. They never return to 0 or X between ops.
//  cmd_* are ignored outside IDLE. A command with cmd_valid=1 waits, and the driver does not sample it.
//  rsp_valid never drops without rsp_ready. rsp_ready while rsp_valid=0 is ignored.
//  All 8 OpCodes are forwarded unchanged. The driver performs no arithmetic.
//  Reset mid-operation: the in-flight command is discarded, no response is produced, and all
//   outputs go to their reset values immediately.
// CONFIGURATION
//  ALU_DRV_STATS_EN defined: adds outputs stat_ops[15:0] and stat_zero[15:0].
//   stat_ops increments on each response handshake. stat_zero increments on handshakes with Z_flag=1.
//   Both saturate at 16'hFFFF and reset to 0.
//  Not defined: the ports and logic are absent, and the ports and timing are otherwise identical.
// STRUCTURE
//  alu_pkg: OPW=3, the state typedef {IDLE, SETTLE, RESP}, and the rsp_flags bit indices (Z=0, C=1, COUT=2).
//  Single module with no sub-module. The settle counter is a 4-bit local register.
// TESTING (bench uses a stub ALU that returns a fixed table for each OpCode)
//  Reset release: cmd_ready=0 during reset and 1 one edge later; rsp_valid=0; alu_*=0.
//  Single op: A=8'h56, B=8'h5D, op=0, stub Result=8'hB3, flags=3'b000, SETTLE_CYC=1.
//   Expect rsp_valid one edge after accept, rsp_result=8'hB3, rsp_op=0.
//  Backpressure: hold rsp_ready=0 for 5 cycles. rsp_* stay stable, cmd_ready stays 0, and a
//   pending cmd is not accepted until one edge after rsp_ready=1.
//  Sweep OpCode 0..7 back-to-back with rsp_ready=1. Expect 8 responses in order with
//   rsp_op=0..7 and an issue interval of exactly SETTLE_CYC+2.
//  SETTLE_CYC=3: the stub changes Result 2 cycles after the input change, and the response
//   carries the post-change value.
//  rst_n pulsed low while in SETTLE: no response appears and outputs return to reset values.
//   With ALU_DRV_STATS_EN, stat_ops counts only completed handshakes.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation driver: opcode width,
// FSM state encoding and bit positions inside the packed response flags.
package alu_pkg;

  localparam int OPW = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_COUT = 2;

  function automatic logic [OPW-1:0] pack_flags(input logic z, input logic c, input logic cout);
    logic [OPW-1:0] f;
    f            = '0;
    f[FLAG_Z]    = z;
    f[FLAG_C]    = c;
    f[FLAG_COUT] = cout;
    return f;
  endfunction

endpackage

// File: rtl/alu_op_driver.sv
// Sequential initiator for a combinational ALU: holds one command on the ALU inputs,
// waits SETTLE_CYC edges, then returns the sampled result. ALU_DRV_STATS_EN adds counters.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int N          = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_a,
  input  logic [N-1:0]   cmd_b,
  input  logic [OPW-1:0] cmd_op,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [OPW-1:0] alu_opcode,
  input  logic [N-1:0]   alu_result,
  input  logic           alu_z,
  input  logic           alu_c,
  input  logic           alu_cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_result,
  output logic [OPW-1:0] rsp_flags,
`ifdef ALU_DRV_STATS_EN
  output logic [15:0]    stat_ops,
  output logic [15:0]    stat_zero,
`endif
  output logic [OPW-1:0] rsp_op
);

  // SETTLE_CYC is limited to 1..15 so the countdown fits the 4-bit counter.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_t         state_q,      state_d;
  logic           cmd_ready_q,  cmd_ready_d;
  logic           rsp_valid_q,  rsp_valid_d;
  logic [3:0]     cnt_q,        cnt_d;
  logic [N-1:0]   alu_a_q,      alu_a_d;
  logic [N-1:0]   alu_b_q,      alu_b_d;
  logic [OPW-1:0] alu_op_q,     alu_op_d;
  logic [N-1:0]   rsp_result_q, rsp_result_d;
  logic [OPW-1:0] rsp_flags_q,  rsp_flags_d;
  logic [OPW-1:0] rsp_op_q,     rsp_op_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_op_q     <= rsp_op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_op_d     = rsp_op_q;

    case (state_q)
      IDLE: begin
        // cmd_ready is registered so it first rises one edge after reset release.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          alu_a_d     = cmd_a;
          alu_b_d     = cmd_b;
          alu_op_d    = cmd_op;
          cnt_d       = CNT_INIT;
          cmd_ready_d = 1'b0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        cmd_ready_d = 1'b0;
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = pack_flags(alu_z, alu_c, alu_cout);
          rsp_op_d     = alu_op_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        cmd_ready_d = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_op     = rsp_op_q;

`ifdef ALU_DRV_STATS_EN
  logic        rsp_fire;
  logic [15:0] stat_ops_q;
  logic [15:0] stat_zero_q;

  assign rsp_fire = rsp_valid_q && rsp_ready;

  // Saturating counters; only completed response handshakes are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q  <= '0;
      stat_zero_q <= '0;
    end else if (rsp_fire) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (rsp_flags_q[FLAG_Z] && (stat_zero_q != 16'hFFFF)) stat_zero_q <= stat_zero_q + 16'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_zero = stat_zero_q;
`endif

endmodule
